st7735_rx: RTL and testbench
============================

ST7735_RX -- requirements
Module: st7735_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of SYSTEM_CLK flops synchronising each serial input (legal 2..3).
REQ-002 SHALL have parameter PARAM_MAX, default 31, saturation value of PARAM_IDX.
REQ-003 SYSTEM_CLK  input  1  sole clock; all state on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 LCD_CS  input  1  serial chip select, active-low.
REQ-006 LCD_CLK  input  1  serial clock, data sampled on rising edge.
REQ-007 LCD_MOSI  input  1  serial data, MSB first.
REQ-008 LCD_DC  input  1  0 = command byte, 1 = data byte.
REQ-009 RX_DATA  output  8  last completed byte.
REQ-010 RX_DC  output  1  LCD_DC value captured with bit 0 of RX_DATA.
REQ-011 RX_VALID  output  1  one-cycle strobe, RX_DATA/RX_DC new.
REQ-012 CMD  output  8  most recent command byte.
REQ-013 PARAM_IDX  output  5  index of current data byte after CMD (first = 0).
REQ-014 FRAME_ERR  output  1  one-cycle strobe, CS deasserted mid-byte.
REQ-015 ERR_COUNT  output  8  aborted-byte count (see Configuration).

Function
REQ-016 All four serial inputs SHALL pass through SYNC_STAGES flops; edge detection uses the last two synchronised LCD_CLK samples.
REQ-017 Serial timing SHALL be supported for LCD_CLK high and low each >= 2 SYSTEM_CLK periods plus SYNC skew; faster input is unsupported.
REQ-018 FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT when synchronised CS = 0; any state->IDLE when synchronised CS = 1.
REQ-019 In SHIFT each synchronised LCD_CLK rising edge SHALL shift synchronised MOSI into an 8-bit register LSB-side and increment a 3-bit bit counter.
REQ-020 On the 8th edge SHALL latch the byte into RX_DATA, synchronised DC into RX_DC, and assert RX_VALID the following cycle for exactly one cycle; bit counter wraps to 0 and FSM stays in SHIFT.
REQ-021 Back-to-back bytes with CS held low SHALL each produce one RX_VALID; no gap cycles required.
REQ-022 Command byte (RX_DC = 0) SHALL update CMD and reset PARAM_IDX to 0 in the same cycle RX_VALID asserts.
REQ-023 Data byte SHALL report PARAM_IDX equal to data bytes since last command minus one, valid while RX_VALID high, then increment; saturates at PARAM_MAX.
REQ-024 CS rising with bit counter != 0 SHALL discard the partial byte, assert FRAME_ERR one cycle, no RX_VALID; CS rising with counter = 0 SHALL be silent.
REQ-025 LCD_CLK edges while CS high SHALL be ignored.
REQ-026 CS rising and 8th LCD_CLK edge detected in same cycle SHALL complete the byte (RX_VALID), no FRAME_ERR.
REQ-027 Data bytes before any command SHALL be delivered with CMD = 8'h00.

Reset
REQ-028 RESET_N low SHALL immediately force IDLE, bit counter 0, synchronisers to CS = 1/CLK = 1, RX_DATA 8'h00, RX_DC 0, RX_VALID 0, CMD 8'h00, PARAM_IDX 0, FRAME_ERR 0, ERR_COUNT 0.
REQ-029 Reset mid-byte SHALL discard the partial byte without FRAME_ERR; reception resumes on next CS falling edge after release.

Configuration
REQ-030 Macro ST7735_RX_ERRCNT_EN defined: ERR_COUNT SHALL increment on each FRAME_ERR, saturating at 8'hFF.
REQ-031 Macro undefined: ERR_COUNT SHALL be constant 8'h00 and counter logic SHALL be absent.

Verification
REQ-032 CS low, DC 0, send 8'h11, CS high -> one RX_VALID, RX_DATA 8'h11, RX_DC 0, CMD 8'h11, no FRAME_ERR.
REQ-033 CS low, cmd 8'hB1 then data 8'h05, 8'h3C, 8'h3C one frame -> four RX_VALID; data bytes PARAM_IDX 0,1,2; CMD 8'hB1.
REQ-034 Cmd 8'hE0 followed by 40 data bytes -> PARAM_IDX saturates at 31 for bytes 32..40, all 41 bytes delivered.
REQ-035 Send 5 bits then CS high -> FRAME_ERR one cycle, no RX_VALID, ERR_COUNT 1 with ST7735_RX_ERRCNT_EN, 0 without; next full byte 8'h3A received correctly.
REQ-036 Toggle LCD_CLK 16 times with CS high, then send 8'h29 -> exactly one RX_VALID, RX_DATA 8'h29.
REQ-037 Assert RESET_N low after 4 bits of a byte, release, send 8'hC0 -> all outputs at reset values, no FRAME_ERR, then RX_DATA 8'hC0.

Source files
------------

// File: rtl/st7735_rx_if.sv
// Serial LCD bus (ST7735 style SPI with D/C line) plus decoded receive outputs.
// The serial host drives the master side; the receiver uses the slave side.
interface st7735_rx_if;
  logic       LCD_CS;
  logic       LCD_CLK;
  logic       LCD_MOSI;
  logic       LCD_DC;
  logic [7:0] RX_DATA;
  logic       RX_DC;
  logic       RX_VALID;
  logic [7:0] CMD;
  logic [4:0] PARAM_IDX;
  logic       FRAME_ERR;
  logic [7:0] ERR_COUNT;

  modport master (
    output LCD_CS, LCD_CLK, LCD_MOSI, LCD_DC,
    input  RX_DATA, RX_DC, RX_VALID, CMD, PARAM_IDX, FRAME_ERR, ERR_COUNT
  );

  modport slave (
    input  LCD_CS, LCD_CLK, LCD_MOSI, LCD_DC,
    output RX_DATA, RX_DC, RX_VALID, CMD, PARAM_IDX, FRAME_ERR, ERR_COUNT
  );
endinterface

// File: rtl/st7735_rx.sv
// ST7735 serial byte receiver: oversampled SPI slave with command/parameter tracking.
// Define ST7735_RX_ERRCNT_EN to build the saturating aborted-byte counter on ERR_COUNT.
module st7735_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARAM_MAX   = 31
) (
  input  logic          SYSTEM_CLK,
  input  logic          RESET_N,
  st7735_rx_if.slave    bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PARAM_MAX);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, mosi_sync, dc_sync;
  logic                   clk_d;
  logic                   cs_s, clk_s, mosi_s, dc_s, clk_rise;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]   shift_reg, shift_reg_n;
  logic [BYTE_W-1:0]   rx_data, rx_data_n;
  logic                rx_dc, rx_dc_n;
  logic                rx_valid, rx_valid_n;
  logic [BYTE_W-1:0]   cmd, cmd_n;
  logic [IDX_W-1:0]    param_idx, param_idx_n;
  logic                frame_err, frame_err_n;

  // Idle-high reset values keep CS and CLK from looking like edges after reset.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      clk_sync  <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      clk_d     <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.LCD_CS};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0],  bus.LCD_CLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.LCD_MOSI};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   bus.LCD_DC};
      clk_d     <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_dc     <= 1'b0;
      rx_valid  <= 1'b0;
      cmd       <= '0;
      param_idx <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      rx_data   <= rx_data_n;
      rx_dc     <= rx_dc_n;
      rx_valid  <= rx_valid_n;
      cmd       <= cmd_n;
      param_idx <= param_idx_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    rx_data_n   = rx_data;
    rx_dc_n     = rx_dc;
    rx_valid_n  = 1'b0;
    cmd_n       = cmd;
    param_idx_n = param_idx;
    frame_err_n = 1'b0;

    // Parameter index advances once the data byte's strobe has been presented.
    if (rx_valid && rx_dc && (param_idx < IDX_MAX)) begin
      param_idx_n = param_idx + IDX_W'(1);
    end

    case (state)
      ST_IDLE: begin
        bit_cnt_n = '0;
        if (!cs_s) begin
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // An edge seen together with CS rising still counts, so a final bit completes.
        if (clk_rise) begin
          shift_reg_n = {shift_reg[BYTE_W-2:0], mosi_s};
          bit_cnt_n   = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            rx_data_n  = shift_reg_n;
            rx_dc_n    = dc_s;
            rx_valid_n = 1'b1;
            if (!dc_s) begin
              cmd_n       = shift_reg_n;
              param_idx_n = '0;
            end
          end
        end
        if (cs_s) begin
          frame_err_n = (bit_cnt_n != '0);
          bit_cnt_n   = '0;
          state_n     = ST_IDLE;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
      end
    endcase
  end

  assign bus.RX_DATA   = rx_data;
  assign bus.RX_DC     = rx_dc;
  assign bus.RX_VALID  = rx_valid;
  assign bus.CMD       = cmd;
  assign bus.PARAM_IDX = param_idx;
  assign bus.FRAME_ERR = frame_err;

`ifdef ST7735_RX_ERRCNT_EN
  logic [BYTE_W-1:0] err_count;

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_count <= '0;
    end else if (frame_err && (err_count != '1)) begin
      err_count <= err_count + BYTE_W'(1);
    end
  end

  assign bus.ERR_COUNT = err_count;
`else
  assign bus.ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_st7735_rx.sv
// Scoreboard bench for st7735_rx: expected bytes queued as they are sent,
// matched against bytes captured on RX_VALID.
module tb_st7735_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
    logic [7:0] cmd;
    logic [4:0] idx;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  st7735_rx_if bus();

  st7735_rx #(.SYNC_STAGES(2), .PARAM_MAX(31)) dut (
    .SYSTEM_CLK (clk),
    .RESET_N    (rst_n),
    .bus        (bus)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t obs_a[0:255];
  int   n_obs = 0;
  int   rd_ptr = 0;
  int   fe_cnt = 0;
  int   fe_long = 0;
  int   rv_long = 0;
  logic rv_prev = 1'b0;
  logic fe_prev = 1'b0;

  logic [7:0] model_cmd = 8'h00;
  int         model_cnt = 0;
  int         model_err = 0;

  // Capture every output strobe away from the active edge.
  always @(negedge clk) begin
    rv_prev <= bus.RX_VALID;
    fe_prev <= bus.FRAME_ERR;
    if (bus.RX_VALID) begin
      obs_a[n_obs[7:0]] <= '{bus.RX_DATA, bus.RX_DC, bus.CMD, bus.PARAM_IDX};
      n_obs <= n_obs + 1;
      if (rv_prev) rv_long <= rv_long + 1;
    end
    if (bus.FRAME_ERR) begin
      fe_cnt <= fe_cnt + 1;
      if (fe_prev) fe_long <= fe_long + 1;
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic dc);
    rec_t e;
    if (!dc) begin
      model_cmd = b;
      model_cnt = 0;
      e = '{b, dc, b, 5'd0};
    end else begin
      e = '{b, dc, model_cmd, 5'(model_cnt)};
      if (model_cnt < 31) model_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic cs_low();
    bus.LCD_CS = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40;
    bus.LCD_CS = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.LCD_MOSI = b[7-i];
      bus.LCD_DC   = dc;
      #40;
      bus.LCD_CLK = 1'b1;
      #40;
      bus.LCD_CLK = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
    push_exp(b, dc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.LCD_CS = 1'b1; bus.LCD_CLK = 1'b0; bus.LCD_MOSI = 1'b0; bus.LCD_DC = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.RX_DATA, bus.RX_DC, bus.RX_VALID} !== 10'h0) begin
      errors++; $display("FAIL reset_rx got %h/%b/%b want 00/0/0", bus.RX_DATA, bus.RX_DC, bus.RX_VALID);
    end
    checks++;
    if ({bus.CMD, bus.PARAM_IDX} !== 13'h0) begin
      errors++; $display("FAIL reset_cmd got %h/%0d want 00/0", bus.CMD, bus.PARAM_IDX);
    end
    checks++;
    if ({bus.FRAME_ERR, bus.ERR_COUNT} !== 9'h0) begin
      errors++; $display("FAIL reset_err got %b/%0d want 0/0", bus.FRAME_ERR, bus.ERR_COUNT);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_data_before_cmd();
    rec_t e;
    cs_low(); send_byte(8'h5A, 1'b1); cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL precmd missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL precmd byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr) begin errors++; $display("FAIL precmd count got %0d want %0d", n_obs, rd_ptr); rd_ptr = n_obs; end
  endtask

  task automatic test_single_cmd();
    rec_t e;
    int fe0 = fe_cnt;
    cs_low(); send_byte(8'h11, 1'b0); cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL cmd11 missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL cmd11 byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr) begin errors++; $display("FAIL cmd11 count got %0d want %0d", n_obs, rd_ptr); rd_ptr = n_obs; end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL cmd11 frame_err got %0d want %0d", fe_cnt - fe0, 0); end
  endtask

  task automatic test_params();
    rec_t e;
    logic [7:0] bytes [4] = '{8'hB1, 8'h05, 8'h3C, 8'h3C};
    cs_low();
    foreach (bytes[i]) send_byte(bytes[i], (i != 0));
    cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL params missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL params byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr) begin errors++; $display("FAIL params count got %0d want %0d", n_obs, rd_ptr); rd_ptr = n_obs; end
  endtask

  task automatic test_saturation();
    rec_t e;
    int start = n_obs;
    cs_low();
    send_byte(8'hE0, 1'b0);
    for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL sat missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL sat byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs - start != 41) begin errors++; $display("FAIL sat count got %0d want %0d", n_obs - start, 41); rd_ptr = n_obs; end
  endtask

  task automatic test_frame_err();
    rec_t e;
    int fe0 = fe_cnt;
    int ob0 = n_obs;
    cs_low(); send_bits(8'hF8, 1'b0, 5); cs_high();
`ifdef ST7735_RX_ERRCNT_EN
    if (model_err < 255) model_err++;
`endif
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr pulses got %0d want %0d", fe_cnt - fe0, 1); end
    checks++;
    if (n_obs != ob0) begin errors++; $display("FAIL ferr rx_valid got %0d want %0d", n_obs - ob0, 0); rd_ptr = n_obs; end
    checks++;
    if (bus.ERR_COUNT !== 8'(model_err)) begin errors++; $display("FAIL ferr err_count got %0d want %0d", bus.ERR_COUNT, model_err); end
    cs_low(); send_byte(8'h3A, 1'b0); cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL ferr_next missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL ferr_next byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr) begin errors++; $display("FAIL ferr_next count got %0d want %0d", n_obs, rd_ptr); rd_ptr = n_obs; end
  endtask

  task automatic test_clk_while_cs_high();
    rec_t e;
    int fe0 = fe_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.LCD_MOSI = 1'($urandom_range(0, 1));
      bus.LCD_CLK = 1'b1; #40;
      bus.LCD_CLK = 1'b0; #40;
    end
    cs_low(); send_byte(8'h29, 1'b0); cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL csidle missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL csidle byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr || fe_cnt != fe0) begin
      errors++; $display("FAIL csidle count got %0d/%0d want %0d/%0d", n_obs, fe_cnt, rd_ptr, fe0); rd_ptr = n_obs;
    end
  endtask

  task automatic test_cs_on_last_edge();
    rec_t e;
    int fe0 = fe_cnt;
    cs_low();
    send_bits(8'hA5, 1'b1, 7);
    bus.LCD_MOSI = 1'b1;
    #40;
    bus.LCD_CLK = 1'b1;
    bus.LCD_CS  = 1'b1;
    #40;
    bus.LCD_CLK = 1'b0;
    push_exp(8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL lastedge missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL lastedge byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL lastedge frame_err got %0d want %0d", fe_cnt - fe0, 0); end
  endtask

  task automatic test_reset_mid_byte();
    rec_t e;
    int fe0 = fe_cnt;
    cs_low();
    send_bits(8'h90, 1'b1, 4);
    rst_n = 1'b0;
    #22;
    checks++;
    if ({bus.RX_DATA, bus.RX_DC, bus.RX_VALID, bus.CMD, bus.PARAM_IDX, bus.FRAME_ERR, bus.ERR_COUNT} !== 32'h0) begin
      errors++;
      $display("FAIL midreset outputs got %h/%b/%b/%h/%0d/%b/%0d want all zero",
               bus.RX_DATA, bus.RX_DC, bus.RX_VALID, bus.CMD, bus.PARAM_IDX, bus.FRAME_ERR, bus.ERR_COUNT);
    end
    bus.LCD_CS = 1'b1;
    #30;
    rst_n = 1'b1;
    model_cmd = 8'h00; model_cnt = 0; model_err = 0;
    repeat (20) @(posedge clk);
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL midreset frame_err got %0d want %0d", fe_cnt - fe0, 0); end
    cs_low(); send_byte(8'hC0, 1'b0); cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= n_obs) begin errors++; $display("FAIL midreset missing got none want %h", e.data); end
      else begin
        if (obs_a[rd_ptr[7:0]] !== e) begin errors++; $display("FAIL midreset byte got %h want %h", obs_a[rd_ptr[7:0]], e); end
        rd_ptr++;
      end
    end
    checks++;
    if (n_obs != rd_ptr) begin errors++; $display("FAIL midreset count got %0d want %0d", n_obs, rd_ptr); rd_ptr = n_obs; end
  endtask

  initial begin
    test_reset();
    test_data_before_cmd();
    test_single_cmd();
    test_params();
    test_saturation();
    test_frame_err();
    test_clk_while_cs_high();
    test_cs_on_last_edge();
    test_reset_mid_byte();
    checks++;
    if (rv_long != 0 || fe_long != 0) begin
      errors++; $display("FAIL strobe_width got %0d/%0d want 0/0", rv_long, fe_long);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
